fetch_steer_ctrl: RTL and testbench
===================================

Name: fetch_steer_ctrl

Overview:
Controller for the instruction-fetch stage; the IF stage contains the PC register, the 2-bit predictor, the BHT, the BTB and the instruction memory.
- Each cycle it selects the next PC from: sequential, BTB-predicted target, or EX-resolved redirect.
- Tracks in-flight predicted branches in a small queue and detects mispredictions.
- On a misprediction it flushes the front-end and issues BHT/BTB update strobes.
- Replaces direct PCSrc/t_addr steering of the PC.

Parameters:
XLEN, 32, address/data width
QDEPTH, 4, in-flight prediction queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
CNT_W, 16, mispredict counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
hz_stall  input  1  hazard unit requests PC hold
fetch_pc  input  XLEN  PC currently presented to instruction memory
pred_hit  input  1  BTB hit for fetch_pc
pred_taken  input  1  predictor MSB for fetch_pc
pred_target  input  XLEN  BTB target for fetch_pc
ex_valid  input  1  EX stage holds a valid instruction
ex_is_br  input  1  EX instruction is a conditional branch or jump
ex_pc  input  XLEN  PC of EX instruction
ex_taken  input  1  resolved direction
ex_target  input  XLEN  resolved target
next_pc  output  XLEN  value loaded into PC at next edge
pc_write  output  1  PC load enable
flush_if_id  output  1  invalidate IF/ID
flush_id_ex  output  1  invalidate ID/EX
upd_en  output  1  BHT/BTB update strobe
upd_pc  output  XLEN  update index
upd_taken  output  1  resolved direction to BHT
upd_target  output  XLEN  target to BTB (valid when upd_taken)
q_full  output  1  prediction queue full
mispred_cnt  output  CNT_W  saturating mispredict count

Behaviour:
- Reset (rst=0, async):
  - state=BOOT, queue empty.
  - mispred_cnt=0; upd_en=0; flushes=0; pc_write=0; next_pc=RESET_PC.
- FSM states: BOOT, RUN, FULL.
- BOOT:
  - Lasts one cycle after reset release.
  - next_pc=RESET_PC, pc_write=1, no push.
  - Then go to RUN.
- RUN next_pc priority (combinational, same cycle):
  1. mispredict: next_pc = ex_taken ? ex_target : ex_pc+4.
  2. pred_hit && pred_taken: next_pc = pred_target.
  3. Otherwise: next_pc = fetch_pc+4.
  - All +4 arithmetic wraps mod 2^XLEN.
- pc_write:
  - =1 on mispredict, even if hz_stall or queue full.
  - Otherwise = !hz_stall && !(state==FULL).
- Push:
  - Condition: pc_write && pred_hit && !mispredict && state!=BOOT.
  - Entry stored: {fetch_pc, pred_taken, pred_target}.
- Resolve (ex_valid && ex_is_br), per cycle:
  - head_match = queue non-empty && head.pc == ex_pc.
  - Predicted values: if head_match, the head entry's taken/target; else taken=0.
  - If head_match, pop the head.
  - mispredict = (ex_taken != predicted taken) || (ex_taken && predicted taken && ex_target != predicted target).
- Update strobe:
  - upd_en=1 for every resolve, same cycle.
  - upd_pc=ex_pc, upd_taken=ex_taken, upd_target=ex_target.
- Mispredict cycle:
  - flush_if_id=1, flush_id_ex=1.
  - Queue cleared at the edge; the clear overrides a simultaneous push or pop.
  - mispred_cnt+1, saturating at all-ones.
- FULL:
  - Entered when the count reaches QDEPTH after a push.
  - Fetch held (pc_write=0) until a pop or a mispredict, then return to RUN.
  - Simultaneous push and pop: count unchanged.
  - A push is never performed when full.
- Stale entry: a head whose pc is not ex_pc is left in place, with no error.
- Outputs: combinational from state, queue head and inputs; no extra latency. The queue and counters are registered.

Decomposition:
- Shared package (fetch_pkg): state encoding (BOOT/RUN/FULL), the pred-entry struct {pc, taken, target}, and constant INST_BYTES=4.
- Sub-module pred_queue: QDEPTH-entry FIFO with push, pop, clear, head, count and full.

Test Plan:
- Reset release -> BOOT cycle: next_pc=0, pc_write=1. Next cycle: fetch_pc=0, next_pc=4, queue empty.
- fetch_pc=0x10, pred_hit=1, taken=1, target=0x40 -> next_pc=0x40, push. Later EX resolve pc=0x10, taken=1, target=0x40 -> pop, upd_en=1, no flush, mispred_cnt=0.
- Queued prediction (pc=0x20, taken=1) resolved ex_taken=0 -> next_pc=0x24, both flushes=1, queue empty next cycle, mispred_cnt=1.
- No BTB hit. Branch at 0x30 resolves taken to 0x80 -> mispredict, next_pc=0x80; mispredict occurs with hz_stall=1 -> pc_write still 1.
- Four predicted pushes with no resolve -> q_full=1, pc_write=0. One matching resolve -> pop, return to RUN, pc_write=1 the following cycle.
- Assert rst low mid-mispredict with mispred_cnt=5 -> outputs return to reset values immediately, queue empty, count 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-steering controller.
package fetch_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {BOOT, RUN, FULL} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } pred_entry_t;

endpackage

// File: rtl/pred_queue.sv
// pred_queue: FIFO of in-flight predictions with push, pop and a dominant clear.
module pred_queue #(
    parameter  int W     = 65,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clear) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/fetch_steer_ctrl.sv
// fetch_steer_ctrl: next-PC selection, prediction tracking and mispredict recovery.
module fetch_steer_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic             pred_hit,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic [XLEN-1:0]  next_pc,
    output logic             pc_write,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             upd_en,
    output logic [XLEN-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [XLEN-1:0]  upd_target,
    output logic             q_full,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int AW = $clog2(QDEPTH);
    localparam int EW = 2 * XLEN + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]    head;
    logic [AW:0]      qcount, qcount_nxt;
    logic             qfull, qempty;
    logic [XLEN-1:0]  h_pc, h_tgt;
    logic             h_taken;
    logic             resolve, head_match, p_taken, mispredict, push, pop;

    assign {h_pc, h_taken, h_tgt} = head;

    pred_queue #(.W(EW), .DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (mispredict),
        .din   ({fetch_pc, pred_taken, pred_target}),
        .head  (head),
        .count (qcount),
        .full  (qfull),
        .empty (qempty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BOOT is also the state held during reset, so gating on it forces idle outputs.
    always_comb begin
        resolve     = state_q != BOOT && ex_valid && ex_is_br;
        head_match  = !qempty && h_pc == ex_pc;
        p_taken     = head_match && h_taken;
        pop         = resolve && head_match;
        mispredict  = resolve && (ex_taken != p_taken || (ex_taken && p_taken && ex_target != h_tgt));
        pc_write    = state_q == BOOT ? rst : mispredict || (!hz_stall && state_q != FULL);
        push        = pc_write && pred_hit && !mispredict && state_q != BOOT;
        next_pc     = state_q == BOOT ? RESET_PC :
                      mispredict ? (ex_taken ? ex_target : ex_pc + XLEN'(INST_BYTES)) :
                      (pred_hit && pred_taken) ? pred_target : fetch_pc + XLEN'(INST_BYTES);
        qcount_nxt  = mispredict ? '0 : qcount + (AW+1)'(push) - (AW+1)'(pop);
        state_d     = (state_q == BOOT || mispredict) ? RUN :
                      qcount_nxt == (AW+1)'(QDEPTH) ? FULL : RUN;
        cnt_d       = (mispredict && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        flush_if_id = mispredict;
        flush_id_ex = mispredict;
        upd_en      = resolve;
        upd_pc      = ex_pc;
        upd_taken   = ex_taken;
        upd_target  = ex_target;
        q_full      = qfull;
        mispred_cnt = cnt_q;
    end

endmodule

// File: tb/tb_fetch_steer_ctrl.sv
// tb_fetch_steer_ctrl: directed vectors with a scoreboard queue drained by a negedge monitor.
module tb_fetch_steer_ctrl;

    logic        clk = 0;
    logic        rst = 0;
    logic        hz_stall = 0;
    logic [31:0] fetch_pc = 0;
    logic        pred_hit = 0;
    logic        pred_taken = 0;
    logic [31:0] pred_target = 0;
    logic        ex_valid = 0;
    logic        ex_is_br = 0;
    logic [31:0] ex_pc = 0;
    logic        ex_taken = 0;
    logic [31:0] ex_target = 0;
    logic [31:0] next_pc, upd_pc, upd_target;
    logic        pc_write, flush_if_id, flush_id_ex, upd_en, upd_taken, q_full;
    logic [15:0] mispred_cnt;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       nm;
        logic [31:0] npc;
        logic        pcw, fl, upd, qf;
        logic [15:0] cnt;
        logic [31:0] upc, utgt;
        logic        ut;
    } exp_t;

    exp_t sb[$];

    fetch_steer_ctrl dut (
        .clk(clk), .rst(rst), .hz_stall(hz_stall), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .next_pc(next_pc), .pc_write(pc_write),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .upd_en(upd_en),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .q_full(q_full), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic r, input logic hz, input logic [31:0] fpc,
                       input logic hit, input logic pt, input logic [31:0] ptgt, input logic [1:0] ex,
                       input logic [31:0] expc, input logic ext, input logic [31:0] extgt,
                       input logic [31:0] e_npc, input logic e_pcw, input logic e_fl,
                       input logic e_upd, input logic e_qf, input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hz_stall = hz; fetch_pc = fpc; pred_hit = hit; pred_taken = pt; pred_target = ptgt;
        ex_valid = ex[1]; ex_is_br = ex[0]; ex_pc = expc; ex_taken = ext; ex_target = extgt;
        e.nm = nm; e.npc = e_npc; e.pcw = e_pcw; e.fl = e_fl; e.upd = e_upd; e.qf = e_qf;
        e.cnt = e_cnt; e.upc = expc; e.ut = ext; e.utgt = extgt;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "next_pc", next_pc, e.npc);
            chk(e.nm, "pc_write", 32'(pc_write), 32'(e.pcw));
            chk(e.nm, "flush_if_id", 32'(flush_if_id), 32'(e.fl));
            chk(e.nm, "flush_id_ex", 32'(flush_id_ex), 32'(e.fl));
            chk(e.nm, "upd_en", 32'(upd_en), 32'(e.upd));
            chk(e.nm, "q_full", 32'(q_full), 32'(e.qf));
            chk(e.nm, "mispred_cnt", 32'(mispred_cnt), 32'(e.cnt));
            if (e.upd) begin
                chk(e.nm, "upd_pc", upd_pc, e.upc);
                chk(e.nm, "upd_taken", 32'(upd_taken), 32'(e.ut));
                if (e.ut) chk(e.nm, "upd_target", upd_target, e.utgt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //   name        r hz fetch  hit pt ptgt   ex     expc  t  extgt    npc   pcw fl upd qf cnt
        cyc("reset",     0, 0, 0,     0, 0, 0,     2'b00, 0,    0, 0,      0,     0, 0, 0, 0, 0);
        cyc("boot",      1, 0, 0,     0, 0, 0,     2'b00, 0,    0, 0,      0,     1, 0, 0, 0, 0);
        cyc("seq0",      1, 0, 0,     0, 0, 0,     2'b10, 'h8,  1, 'h88,   'h4,   1, 0, 0, 0, 0);
        cyc("pred",      1, 0, 'h10,  1, 1, 'h40,  2'b00, 0,    0, 0,      'h40,  1, 0, 0, 0, 0);
        cyc("hit_res",   1, 0, 'h40,  0, 0, 0,     2'b11, 'h10, 1, 'h40,   'h44,  1, 0, 1, 0, 0);
        cyc("pred2",     1, 0, 'h20,  1, 1, 'h60,  2'b00, 0,    0, 0,      'h60,  1, 0, 0, 0, 0);
        cyc("mis_nt",    1, 0, 'h60,  0, 0, 0,     2'b11, 'h20, 0, 0,      'h24,  1, 1, 1, 0, 0);
        cyc("post_mis",  1, 0, 'h24,  0, 0, 0,     2'b00, 0,    0, 0,      'h28,  1, 0, 0, 0, 1);
        cyc("mis_stall", 1, 1, 'h28,  0, 0, 0,     2'b11, 'h30, 1, 'h80,   'h80,  1, 1, 1, 0, 1);
        cyc("stall",     1, 1, 'h80,  0, 0, 0,     2'b00, 0,    0, 0,      'h84,  0, 0, 0, 0, 2);
        cyc("pred3",     1, 0, 'h90,  1, 1, 'hA0,  2'b00, 0,    0, 0,      'hA0,  1, 0, 0, 0, 2);
        cyc("stale_mis", 1, 0, 'hA0,  1, 1, 'hB0,  2'b11, 'h50, 1, 'h70,   'h70,  1, 1, 1, 0, 2);
        cyc("clr_chk",   1, 0, 'h70,  0, 0, 0,     2'b11, 'h90, 1, 'hA0,   'hA0,  1, 1, 1, 0, 3);
        cyc("pred4",     1, 0, 'hC0,  1, 1, 'hD0,  2'b00, 0,    0, 0,      'hD0,  1, 0, 0, 0, 4);
        cyc("stale",     1, 0, 'hD0,  0, 0, 0,     2'b11, 'h34, 0, 0,      'hD4,  1, 0, 1, 0, 4);
        cyc("stale_hit", 1, 0, 'hD4,  0, 0, 0,     2'b11, 'hC0, 1, 'hD0,   'hD8,  1, 0, 1, 0, 4);
        cyc("fill0",     1, 0, 'h100, 1, 1, 'h200, 2'b00, 0,    0, 0,      'h200, 1, 0, 0, 0, 4);
        cyc("fill1",     1, 0, 'h200, 1, 1, 'h300, 2'b00, 0,    0, 0,      'h300, 1, 0, 0, 0, 4);
        cyc("fill2",     1, 0, 'h300, 1, 1, 'h400, 2'b00, 0,    0, 0,      'h400, 1, 0, 0, 0, 4);
        cyc("fill3",     1, 0, 'h400, 1, 1, 'h500, 2'b00, 0,    0, 0,      'h500, 1, 0, 0, 0, 4);
        cyc("full",      1, 0, 'h500, 1, 1, 'h600, 2'b00, 0,    0, 0,      'h600, 0, 0, 0, 1, 4);
        cyc("full_pop",  1, 0, 'h500, 0, 0, 0,     2'b11, 'h100,1, 'h200,  'h504, 0, 0, 1, 1, 4);
        cyc("refill",    1, 0, 'h500, 0, 0, 0,     2'b00, 0,    0, 0,      'h504, 1, 0, 0, 0, 4);
        cyc("mis5",      1, 0, 'h504, 0, 0, 0,     2'b11, 'h600,1, 'h700,  'h700, 1, 1, 1, 0, 4);
        cyc("rst_mid",   0, 0, 'h700, 0, 0, 0,     2'b11, 'h700,1, 'h900,  0,     0, 0, 0, 0, 0);
        cyc("rst_hold",  0, 0, 'h700, 0, 0, 0,     2'b11, 'h700,1, 'h900,  0,     0, 0, 0, 0, 0);
        cyc("boot2",     1, 0, 0,     0, 0, 0,     2'b00, 0,    0, 0,      0,     1, 0, 0, 0, 0);
        cyc("empty2",    1, 0, 0,     0, 0, 0,     2'b11, 'h200,1, 'h300,  'h300, 1, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
